// File: rtl/requant_pack.sv
// rtl/requant_pack.sv - int32 accumulator requantizer (scale, rounding shift, zero point, clamp) packing LANES int8 results per word.
// Define REQUANT_RELU_EN to raise the clamp floor to CFG_ZP (fused quantized ReLU).
module requant_pack #(
  parameter int LANES = 4
) (
  input  logic                 ACLK,
  input  logic                 ARESET,
  input  logic                 SD_AXIS_TVALID,
  output logic                 SD_AXIS_TREADY,
  input  logic [31:0]          SD_AXIS_TDATA,
  input  logic                 SD_AXIS_TLAST,
  output logic                 MO_AXIS_TVALID,
  input  logic                 MO_AXIS_TREADY,
  output logic [8*LANES-1:0]   MO_AXIS_TDATA,
  output logic [LANES-1:0]     MO_AXIS_TKEEP,
  output logic                 MO_AXIS_TLAST,
  input  logic [15:0]          CFG_SCALE,
  input  logic [4:0]           CFG_SHIFT,
  input  logic [7:0]           CFG_ZP
);

  localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [CW-1:0] LAST_LANE = CW'(LANES - 1);

  logic                      ce;
  logic                      a_valid, a_last;
  logic signed [47:0]        a_p;
  logic                      b_valid, b_last;
  logic [7:0]                b_y;
  logic [CW-1:0]             cnt;
  logic [8*LANES-1:0]        pack_data;

  logic signed [48:0]        rnd, sum, shifted;
  logic signed [49:0]        biased, lo;
  logic [7:0]                y;
  logic [8*LANES-1:0]        next_word;
  logic [LANES-1:0]          next_keep;
  logic                      close;

  // The whole pipeline freezes only while a finished word is waiting on downstream.
  assign ce             = !(MO_AXIS_TVALID && !MO_AXIS_TREADY);
  assign SD_AXIS_TREADY = ce && !ARESET;

  always_comb begin
    rnd     = (CFG_SHIFT != 5'd0) ? (49'sd1 <<< (CFG_SHIFT - 5'd1)) : 49'sd0;
    sum     = $signed({a_p[47], a_p}) + rnd;
    shifted = sum >>> CFG_SHIFT;
    biased  = $signed({shifted[48], shifted}) + $signed({{42{CFG_ZP[7]}}, CFG_ZP});
`ifdef REQUANT_RELU_EN
    lo      = $signed({{42{CFG_ZP[7]}}, CFG_ZP});
`else
    lo      = -50'sd128;
`endif
    if (biased > 50'sd127)
      y = 8'd127;
    else if (biased < lo)
      y = lo[7:0];
    else
      y = biased[7:0];
  end

  always_comb begin
    next_word = pack_data;
    next_keep = '0;
    for (int i = 0; i < LANES; i++) begin
      if (CW'(i) == cnt)
        next_word[8*i +: 8] = b_y;
      next_keep[i] = (CW'(i) <= cnt);
    end
    close = b_valid && ((cnt == LAST_LANE) || b_last);
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      a_valid        <= 1'b0;
      a_last         <= 1'b0;
      a_p            <= '0;
      b_valid        <= 1'b0;
      b_last         <= 1'b0;
      b_y            <= '0;
      cnt            <= '0;
      pack_data      <= '0;
      MO_AXIS_TVALID <= 1'b0;
      MO_AXIS_TDATA  <= '0;
      MO_AXIS_TKEEP  <= '0;
      MO_AXIS_TLAST  <= 1'b0;
    end else begin
      if (ce) begin
        a_valid <= SD_AXIS_TVALID;
        if (SD_AXIS_TVALID) begin
          a_p    <= $signed(SD_AXIS_TDATA) * $signed({1'b0, CFG_SCALE});
          a_last <= SD_AXIS_TLAST;
        end
        b_valid <= a_valid;
        if (a_valid) begin
          b_y    <= y;
          b_last <= a_last;
        end
        if (b_valid) begin
          if (close) begin
            pack_data <= '0;
            cnt       <= '0;
          end else begin
            pack_data <= next_word;
            cnt       <= cnt + 1'b1;
          end
        end
      end
      // A closing word can only arrive when the output slot is empty or handing off.
      if (ce && close) begin
        MO_AXIS_TVALID <= 1'b1;
        MO_AXIS_TDATA  <= next_word;
        MO_AXIS_TKEEP  <= next_keep;
        MO_AXIS_TLAST  <= b_last;
      end else if (MO_AXIS_TREADY) begin
        MO_AXIS_TVALID <= 1'b0;
      end
    end
  end

endmodule
